// File: rtl/game_over_if.sv
// Event and status bundle between the move-validation logic and the game-over detector.
// new_game/capture_by_p1/capture_by_p2 are single-cycle pulses with no ready; every high cycle is one event.
interface game_over_if #(
  parameter int CNT_W = 4
);
  logic             new_game;
  logic             capture_by_p1;
  logic             capture_by_p2;
  logic [CNT_W-1:0] pawns_p1;
  logic [CNT_W-1:0] pawns_p2;
  logic             Player_1_v;
  logic             Player_2_v;
  logic             game_over_pulse;

  modport master (
    output new_game, capture_by_p1, capture_by_p2,
    input  pawns_p1, pawns_p2, Player_1_v, Player_2_v, game_over_pulse
  );

  modport slave (
    input  new_game, capture_by_p1, capture_by_p2,
    output pawns_p1, pawns_p2, Player_1_v, Player_2_v, game_over_pulse
  );
endinterface

// File: rtl/game_over_detector.sv
// Counts each checkers player's remaining pawns and, after a settle delay that lets the
// final move show on screen, latches the winner flag used by the victory-screen stage.
module game_over_detector #(
  parameter int PAWNS_PER_PLAYER = 12,
  parameter int CNT_W            = 4,
  parameter int SETTLE_CYCLES    = 1024,
  parameter int SETTLE_W         = 11
) (
  input  logic        clk,
  input  logic        reset,
  game_over_if.slave  bus,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    PLAYING = 2'd0,
    SETTLE  = 2'd1,
    P1_WIN  = 2'd2,
    P2_WIN  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]    PAWNS_INIT  = CNT_W'(PAWNS_PER_PLAYER);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  state_t              state, state_nxt;
  logic [SETTLE_W-1:0] settle_cnt, settle_nxt;
  logic [CNT_W-1:0]    pawns_p1_q, pawns_p1_nxt;
  logic [CNT_W-1:0]    pawns_p2_q, pawns_p2_nxt;
  logic                p1_wins_q, p1_wins_nxt;
  logic                p1_v_q, p1_v_nxt;
  logic                p2_v_q, p2_v_nxt;
  logic                pulse_q, pulse_nxt;

  // State register; the outputs are registered alongside so they line up with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= PLAYING;
      settle_cnt <= '0;
      pawns_p1_q <= PAWNS_INIT;
      pawns_p2_q <= PAWNS_INIT;
      p1_wins_q  <= 1'b0;
      p1_v_q     <= 1'b0;
      p2_v_q     <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      pawns_p1_q <= pawns_p1_nxt;
      pawns_p2_q <= pawns_p2_nxt;
      p1_wins_q  <= p1_wins_nxt;
      p1_v_q     <= p1_v_nxt;
      p2_v_q     <= p2_v_nxt;
      pulse_q    <= pulse_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    settle_nxt   = settle_cnt;
    pawns_p1_nxt = pawns_p1_q;
    pawns_p2_nxt = pawns_p2_q;
    p1_wins_nxt  = p1_wins_q;
    if (bus.new_game) begin
      state_nxt    = PLAYING;
      settle_nxt   = '0;
      pawns_p1_nxt = PAWNS_INIT;
      pawns_p2_nxt = PAWNS_INIT;
      p1_wins_nxt  = 1'b0;
    end else begin
      case (state)
        PLAYING: begin
          if (bus.capture_by_p2 && (pawns_p1_q != '0)) pawns_p1_nxt = pawns_p1_q - CNT_W'(1);
          if (bus.capture_by_p1 && (pawns_p2_q != '0)) pawns_p2_nxt = pawns_p2_q - CNT_W'(1);
          // A double wipe-out resolves to player 1, matching the downstream mux priority.
          if ((pawns_p1_nxt == '0) || (pawns_p2_nxt == '0)) begin
            state_nxt   = SETTLE;
            settle_nxt  = '0;
            p1_wins_nxt = (pawns_p2_nxt == '0);
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) state_nxt = p1_wins_q ? P1_WIN : P2_WIN;
          else                           settle_nxt = settle_cnt + SETTLE_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    p1_v_nxt  = (state_nxt == P1_WIN);
    p2_v_nxt  = (state_nxt == P2_WIN);
    pulse_nxt = (p1_v_nxt || p2_v_nxt) && (state_nxt != state);
  end

  assign bus.pawns_p1        = pawns_p1_q;
  assign bus.pawns_p2        = pawns_p2_q;
  assign bus.Player_1_v      = p1_v_q;
  assign bus.Player_2_v      = p2_v_q;
  assign bus.game_over_pulse = pulse_q;
  assign state_dbg           = state;

endmodule

// File: tb/tb_game_over_detector.sv
// Directed bench for game_over_detector with a short settle delay (4 cycles).
module tb_game_over_detector;

  localparam int CNT_W = 4;
  localparam logic [1:0] ST_PLAYING = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_P1_WIN  = 2'd2;
  localparam logic [1:0] ST_P2_WIN  = 2'd3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] state_dbg;
  int         checks = 0;
  int         errors = 0;
  logic [CNT_W-1:0] exp_q[$];

  game_over_if #(.CNT_W(CNT_W)) bus ();

  game_over_detector #(
    .PAWNS_PER_PLAYER(12),
    .CNT_W           (CNT_W),
    .SETTLE_CYCLES   (4),
    .SETTLE_W        (11)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver tasks: inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drive(input logic ng, input logic c1, input logic c2);
    bus.new_game      = ng;
    bus.capture_by_p1 = c1;
    bus.capture_by_p2 = c2;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input int p1, input int p2,
                               input logic v1, input logic v2, input logic pulse);
    check({tag, ".pawns_p1"}, 32'(bus.pawns_p1), 32'(p1));
    check({tag, ".pawns_p2"}, 32'(bus.pawns_p2), 32'(p2));
    check({tag, ".Player_1_v"}, 32'(bus.Player_1_v), 32'(v1));
    check({tag, ".Player_2_v"}, 32'(bus.Player_2_v), 32'(v2));
    check({tag, ".game_over_pulse"}, 32'(bus.game_over_pulse), 32'(pulse));
  endtask

  initial begin
    logic saw_win;
    drive(1'b0, 1'b0, 1'b0);

    // 1) reset held for two cycles
    steps(2);
    check_outputs("reset", 12, 12, 1'b0, 1'b0, 1'b0);
    check("reset.state", 32'(state_dbg), 32'(ST_PLAYING));
    reset = 1'b0;
    step();

    // 2) twelve player-1 captures; count drops one per pulse, win 5 cycles after the last
    for (int i = 1; i <= 12; i++) exp_q.push_back(CNT_W'(12 - i));
    for (int i = 1; i <= 12; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      step();
      check($sformatf("t2.pawns_p2[%0d]", i), 32'(bus.pawns_p2), 32'(exp_q.pop_front()));
    end
    drive(1'b0, 1'b0, 1'b0);
    check("t2.state_settle", 32'(state_dbg), 32'(ST_SETTLE));
    check_outputs("t2.n1", 12, 0, 1'b0, 1'b0, 1'b0);
    steps(3);
    check_outputs("t2.n4", 12, 0, 1'b0, 1'b0, 1'b0);
    step();
    check_outputs("t2.n5", 12, 0, 1'b1, 1'b0, 1'b1);
    check("t2.state_win", 32'(state_dbg), 32'(ST_P1_WIN));
    step();
    check_outputs("t2.n6", 12, 0, 1'b1, 1'b0, 1'b0);

    drive(1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0);
    check_outputs("t2.new_game", 12, 12, 1'b0, 1'b0, 1'b0);

    // 3) both players reach zero on the same edge -> player 1 wins
    drive(1'b0, 1'b1, 1'b1);
    steps(11);
    drive(1'b0, 1'b0, 1'b0);
    check_outputs("t3.one_each", 1, 1, 1'b0, 1'b0, 1'b0);
    check("t3.state_playing", 32'(state_dbg), 32'(ST_PLAYING));
    drive(1'b0, 1'b1, 1'b1);
    step();
    drive(1'b0, 1'b0, 1'b0);
    check_outputs("t3.both_zero", 0, 0, 1'b0, 1'b0, 1'b0);
    steps(4);
    check_outputs("t3.win", 0, 0, 1'b1, 1'b0, 1'b1);

    drive(1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0);

    // 4) thirteen player-2 captures saturate pawns_p1 at zero
    drive(1'b0, 1'b0, 1'b1);
    steps(13);
    drive(1'b0, 1'b0, 1'b0);
    check_outputs("t4.saturate", 0, 12, 1'b0, 1'b0, 1'b0);
    steps(3);
    check_outputs("t4.win", 0, 12, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    steps(3);
    drive(1'b0, 1'b0, 1'b0);
    check_outputs("t4.ignored", 0, 12, 1'b0, 1'b1, 1'b0);
    check("t4.state", 32'(state_dbg), 32'(ST_P2_WIN));

    // 6) new_game beats a simultaneous capture while in P2_WIN
    drive(1'b1, 1'b1, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0);
    check_outputs("t6.restart", 12, 12, 1'b0, 1'b0, 1'b0);
    check("t6.state", 32'(state_dbg), 32'(ST_PLAYING));

    // 5) new_game during the second settle cycle aborts the win
    drive(1'b0, 1'b1, 1'b0);
    steps(12);
    drive(1'b0, 1'b0, 1'b0);
    check("t5.settle1", 32'(state_dbg), 32'(ST_SETTLE));
    step();
    check("t5.settle2", 32'(state_dbg), 32'(ST_SETTLE));
    drive(1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b0);
    check_outputs("t5.abort", 12, 12, 1'b0, 1'b0, 1'b0);
    check("t5.state", 32'(state_dbg), 32'(ST_PLAYING));
    saw_win = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.Player_1_v || bus.Player_2_v || bus.game_over_pulse) saw_win = 1'b1;
    end
    check("t5.no_win", 32'(saw_win), 32'(0));

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
